// File: rtl/fetch_pkg.sv
// Shared widths, reset PC default, FSM encoding and buffer payload for the fetch stage.
package fetch_pkg;

    localparam int unsigned ADDR_SIZE  = 32;
    localparam int unsigned INSTR_SIZE = 32;

    localparam logic [ADDR_SIZE-1:0] FETCH_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_S_ISSUE = 2'd0,
        FETCH_S_WAIT  = 2'd1,
        FETCH_S_DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_SIZE-1:0]  pc;
        logic [INSTR_SIZE-1:0] instr;
    } fetch_entry_t;

    localparam int unsigned ENTRY_SIZE = $bits(fetch_entry_t);

    function automatic logic [ADDR_SIZE-1:0] word_align(input logic [ADDR_SIZE-1:0] addr);
        return {addr[ADDR_SIZE-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Small synchronous FIFO of {pc, instr} entries between imem responses and the decode register.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  fetch_entry_t     wdata,
    output fetch_entry_t     head_c,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head_c  = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two; clear beats push/pop.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !clear && do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: PC sequencing, single-outstanding imem requests,
// response buffering and the stall/flush-aware register feeding decode.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [ADDR_SIZE-1:0] RESET_PC  = FETCH_RESET_PC,
    parameter int unsigned          BUF_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [ADDR_SIZE-1:0]  imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [INSTR_SIZE-1:0] imem_rdata,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [ADDR_SIZE-1:0]  redirect_pc,
    output logic [ADDR_SIZE-1:0]  PC_out,
    output logic [INSTR_SIZE-1:0] instr_out,
    output logic                  pipeline_out_valid
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    fetch_state_e         state_q;
    fetch_state_e         state_d;
    logic [ADDR_SIZE-1:0] pc_q;
    logic [ADDR_SIZE-1:0] pc_d;
    logic [ADDR_SIZE-1:0] req_pc_q;
    logic [ADDR_SIZE-1:0] req_pc_d;
    logic                 handshake;
    logic                 buf_push;
    logic                 buf_pop;
    logic                 buf_full;
    logic                 buf_empty;
    logic [CNT_W-1:0]     fifo_count;
    fetch_entry_t         buf_wdata;
    fetch_entry_t         buf_head;

    assign imem_addr = pc_q;
    assign buf_wdata = '{pc: req_pc_q, instr: imem_rdata};
    assign buf_pop   = !flush && !stall && !buf_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FETCH_S_ISSUE;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    // Issue guard uses the registered count, so a same-cycle pop never opens a slot early.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        imem_req  = 1'b0;
        handshake = 1'b0;
        buf_push  = 1'b0;

        unique case (state_q)
            FETCH_S_ISSUE: begin
                imem_req = !reset && (fifo_count < CNT_W'(BUF_DEPTH));
                if (imem_req && imem_gnt) begin
                    handshake = 1'b1;
                    pc_d      = pc_q + ADDR_SIZE'(4);
                    req_pc_d  = pc_q;
                    state_d   = FETCH_S_WAIT;
                end
            end
            FETCH_S_WAIT: begin
                if (imem_rvalid) begin
                    buf_push = 1'b1;
                    state_d  = FETCH_S_ISSUE;
                end
            end
            FETCH_S_DRAIN: begin
                if (imem_rvalid) begin
                    state_d = FETCH_S_ISSUE;
                end
            end
            default: state_d = FETCH_S_ISSUE;
        endcase

        // A response still owed by memory must be drained before issuing again.
        if (flush) begin
            pc_d     = word_align(redirect_pc);
            buf_push = 1'b0;
            if (handshake ||
                ((state_q == FETCH_S_WAIT || state_q == FETCH_S_DRAIN) && !imem_rvalid)) begin
                state_d = FETCH_S_DRAIN;
            end else begin
                state_d = FETCH_S_ISSUE;
            end
        end
    end

    fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk    (clk),
        .reset  (reset),
        .push   (buf_push),
        .pop    (buf_pop),
        .clear  (flush),
        .wdata  (buf_wdata),
        .head_c (buf_head),
        .full   (buf_full),
        .empty  (buf_empty),
        .count  (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(buf_push && buf_full && !buf_pop));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            PC_out             <= '0;
            instr_out          <= '0;
            pipeline_out_valid <= 1'b0;
        end else if (flush) begin
            pipeline_out_valid <= 1'b0;
        end else if (!stall) begin
            pipeline_out_valid <= !buf_empty;
            if (!buf_empty) begin
                PC_out    <= buf_head.pc;
                instr_out <= buf_head.instr;
            end
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: behavioural imem responder plus a scoreboard of expected {pc, instr} outputs.
module tb_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] XMASK  = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] PC_out;
    logic [31:0] instr_out;
    logic        pipeline_out_valid;

    int errors = 0;
    int checks = 0;
    int consumed = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp_pc = '0;
    logic        edge_stall = 1'b0;

    int          mem_lat = 1;
    bit          mem_keep_on_reset = 1'b0;
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;
    int          hs_total = 0;
    logic [31:0] hs_addr = '0;

    always #5 clk = ~clk;

    fetch #(
        .RESET_PC  (RST_PC),
        .BUF_DEPTH (2)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .imem_req           (imem_req),
        .imem_addr          (imem_addr),
        .imem_gnt           (imem_gnt),
        .imem_rvalid        (imem_rvalid),
        .imem_rdata         (imem_rdata),
        .stall              (stall),
        .flush              (flush),
        .redirect_pc        (redirect_pc),
        .PC_out             (PC_out),
        .instr_out          (instr_out),
        .pipeline_out_valid (pipeline_out_valid)
    );

    // Memory: responds mem_lat cycles after each handshake with addr ^ XMASK.
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            imem_rvalid = 1'b0;
            if (reset && !mem_keep_on_reset) pend = 1'b0;
            if (pend) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = pend_addr ^ XMASK;
                    pend        = 1'b0;
                end
            end
            if (imem_req === 1'b1 && imem_gnt === 1'b1) begin
                pend      = 1'b1;
                pend_cnt  = mem_lat;
                pend_addr = imem_addr;
                hs_total++;
                hs_addr   = imem_addr;
            end
        end
    end

    // Scoreboard consumer: every unstalled edge that leaves valid high presents a new instruction.
    initial begin
        logic [31:0] exp_pc;
        forever begin
            @(posedge clk);
            edge_stall = stall;
            @(negedge clk);
            if (pipeline_out_valid === 1'b1 && !edge_stall) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected: got pc=%h instr=%h, required no output", PC_out, instr_out);
                end else begin
                    exp_pc = exp_q.pop_front();
                    if (PC_out !== exp_pc || instr_out !== (exp_pc ^ XMASK)) begin
                        errors++;
                        $display("FAIL out_seq: got pc=%h instr=%h, required pc=%h instr=%h",
                                 PC_out, instr_out, exp_pc, exp_pc ^ XMASK);
                    end
                    last_exp_pc = exp_pc;
                    consumed++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load_exp(input logic [31:0] start, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic do_reset(input int lat, input logic gnt);
        @(posedge clk); #1;
        reset = 1'b1; stall = 1'b0; flush = 1'b0; imem_gnt = gnt;
        mem_lat = lat; mem_keep_on_reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        hs_addr = '0;
        load_exp(RST_PC, 64);
    endtask

    task automatic wait_consumed(input int target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (consumed >= target) return;
        end
        checks++; errors++;
        $display("FAIL %s_timeout: consumed=%0d, required %0d", name, consumed, target);
    endtask

    task automatic test_reset;
        @(posedge clk); #1;
        reset = 1'b1; imem_gnt = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = '0;
        mem_lat = 1; mem_keep_on_reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b, required 0", imem_req); end
        checks++; if (pipeline_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", pipeline_out_valid); end
        checks++; if (PC_out !== 32'h0) begin errors++; $display("FAIL reset_pc_out: got %h, required 0", PC_out); end
        checks++; if (instr_out !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h, required 0", instr_out); end
        checks++; if (imem_addr !== RST_PC) begin errors++; $display("FAIL reset_addr: got %h, required %h", imem_addr, RST_PC); end
        @(posedge clk); #1;
        reset = 1'b0;
        load_exp(RST_PC, 64);
    endtask

    task automatic test_stream;
        int target;
        do_reset(1, 1'b1);
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            errors++; $display("FAIL stream_first_req: got req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, RST_PC);
        end
        target = consumed + 3;
        wait_consumed(target, 40, "stream");
    endtask

    task automatic test_stall;
        logic [31:0] hold;
        int base;
        do_reset(1, 1'b1);
        wait_consumed(consumed + 2, 40, "stall_fill");
        stall = 1'b1;
        hold  = last_exp_pc;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (PC_out !== hold || pipeline_out_valid !== 1'b1) begin
                errors++; $display("FAIL stall_hold%0d: got pc=%h valid=%b, required pc=%h valid=1", i, PC_out, pipeline_out_valid, hold);
            end
            if (i >= 3) begin
                checks++;
                if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req_full%0d: got %b, required 0", i, imem_req); end
            end
        end
        checks++;
        if (dut.fifo_count !== 2'd2) begin errors++; $display("FAIL stall_count: got %0d, required 2", dut.fifo_count); end
        #1 stall = 1'b0;
        base = consumed;
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk); #1;
            checks++;
            if (consumed != base + i) begin
                errors++; $display("FAIL stall_release%0d: got consumed=%0d, required %0d", i, consumed, base + i);
            end
        end
    endtask

    task automatic test_flush;
        int hb;
        bit seen;
        do_reset(3, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk); #1;
            if (hs_addr === 32'h0000_010C) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL flush_find_10c: got last addr=%h, required 0000010c", hs_addr); end
        flush = 1'b1; redirect_pc = 32'h0000_0203;
        @(posedge clk); #1;
        flush = 1'b0;
        load_exp(32'h0000_0200, 64);
        hb = hs_total;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL flush_drain_req: got %b, required 0", imem_req); end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            if (hs_total != hb) seen = 1'b1;
        end
        checks++;
        if (!seen || hs_addr !== 32'h0000_0200) begin
            errors++; $display("FAIL flush_next_addr: got %h, required 00000200", hs_addr);
        end
        checks++;
        if (dut.fifo_count !== 2'd0) begin errors++; $display("FAIL flush_stale_dropped: got count=%0d, required 0", dut.fifo_count); end
        wait_consumed(consumed + 2, 60, "flush");
    endtask

    task automatic test_flush_stall;
        do_reset(1, 1'b1);
        wait_consumed(consumed + 2, 40, "flush_stall_fill");
        stall = 1'b1; flush = 1'b1; redirect_pc = 32'h0000_0300;
        @(posedge clk); #1;
        stall = 1'b0; flush = 1'b0;
        load_exp(32'h0000_0300, 64);
        @(negedge clk);
        checks++;
        if (pipeline_out_valid !== 1'b0) begin errors++; $display("FAIL flush_stall_valid: got %b, required 0", pipeline_out_valid); end
        checks++;
        if (dut.fifo_count !== 2'd0) begin errors++; $display("FAIL flush_stall_count: got %0d, required 0", dut.fifo_count); end
        wait_consumed(consumed + 2, 40, "flush_stall");
    endtask

    task automatic test_gnt_low;
        do_reset(1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== RST_PC || pipeline_out_valid !== 1'b0) begin
                errors++; $display("FAIL gnt_low%0d: got req=%b addr=%h valid=%b, required req=1 addr=%h valid=0",
                                   i, imem_req, imem_addr, pipeline_out_valid, RST_PC);
            end
        end
        @(posedge clk); #1;
        imem_gnt = 1'b1;
        wait_consumed(consumed + 2, 40, "gnt_low");
    endtask

    task automatic test_reset_mid;
        int hb;
        bit seen;
        do_reset(2, 1'b1);
        wait_consumed(consumed + 1, 40, "reset_mid_fill");
        hb = hs_total;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            if (hs_total != hb) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL reset_mid_find_wait: got no handshake, required one"); end
        mem_keep_on_reset = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        load_exp(RST_PC, 64);
        @(negedge clk);
        checks++;
        if (PC_out !== 32'h0 || instr_out !== 32'h0 || pipeline_out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_outputs: got pc=%h instr=%h valid=%b, required 0/0/0", PC_out, instr_out, pipeline_out_valid);
        end
        @(negedge clk);
        checks++;
        if (dut.fifo_count !== 2'd0 || imem_req !== 1'b0 || imem_addr !== RST_PC + 32'h4) begin
            errors++; $display("FAIL reset_mid_stale: got count=%0d req=%b addr=%h, required count=0 req=0 addr=%h",
                               dut.fifo_count, imem_req, imem_addr, RST_PC + 32'h4);
        end
        mem_keep_on_reset = 1'b0;
        wait_consumed(consumed + 2, 40, "reset_mid");
    endtask

    initial begin
        reset = 1'b1; imem_gnt = 1'b0; stall = 1'b0; flush = 1'b0; redirect_pc = '0;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_flush_stall();
        test_gnt_low();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- Instruction-fetch stage of the in-order RV32I core; the producer end of the decode stage's pipeline-in interface (PC, instruction, valid, with stall/flush back-pressure).
- Maintains the program counter and issues single-outstanding requests to instruction memory.
- Buffers returned instructions in a small FIFO and presents them to decode through an output register that honours stall and flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BUF_DEPTH, 2, instruction FIFO entries; legal values are 2 or 4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address, word-aligned.
- imem_gnt  in  1  request accepted in this cycle (req && gnt = handshake).
- imem_rvalid  in  1  response data valid, arrives 1 or more cycles after the handshake.
- imem_rdata  in  32  instruction word.
- stall  in  1  decode not accepting; hold the outputs.
- flush  in  1  discard in-flight work and restart at redirect_pc.
- redirect_pc  in  32  new PC, sampled only when flush = 1.
- PC_out  out  32  PC of the presented instruction.
- instr_out  out  32  presented instruction.
- pipeline_out_valid  out  1  PC_out/instr_out are valid.

Behaviour:
- Priority: reset > flush > stall > normal operation.
- Reset values:
  - pc = RESET_PC; FIFO empty; state = S_ISSUE.
  - PC_out = 0, instr_out = 0, pipeline_out_valid = 0.
  - imem_req = 0 during the reset cycle.
- FSM states:
  - S_ISSUE: no request outstanding.
    - imem_req = (fifo_count < BUF_DEPTH); imem_addr = pc.
    - On req && gnt: pc <= pc + 4 (wraps modulo 2^32), go to S_WAIT.
  - S_WAIT: one request outstanding; imem_req = 0.
    - On rvalid: push {pc_of_req, rdata} into the FIFO, go to S_ISSUE.
    - pc_of_req is held in a register captured at the handshake.
  - S_DRAIN: the outstanding response is stale; imem_req = 0.
    - On rvalid: drop the data, go to S_ISSUE.
- Issue guard: fifo_count is the registered value; a same-cycle pop does not enable issue. Because only one request is outstanding, the FIFO never overflows.
- Output register:
  - If !stall: load the FIFO head and pop it when non-empty, setting pipeline_out_valid = 1. If the FIFO is empty, pipeline_out_valid = 0.
  - If stall: hold PC_out, instr_out and pipeline_out_valid.
- Latency: an rvalid sampled at edge E writes the FIFO at E; the instruction appears on the outputs after edge E+1 if not stalled. Best case, handshake to visible output is 3 edges with 1-cycle memory latency.
- A FIFO push and pop in the same cycle are both performed; the count is unchanged.
- Flush (takes effect at the edge where flush = 1):
  - pc <= {redirect_pc[31:2], 2'b00}; FIFO cleared; pipeline_out_valid <= 0.
  - In S_WAIT without rvalid this cycle: go to S_DRAIN.
  - In S_WAIT with rvalid this cycle: drop the data, go to S_ISSUE.
  - In S_ISSUE with req && gnt this cycle: the handshake is counted, go to S_DRAIN, and pc is still set to redirect_pc.
  - Otherwise: go to S_ISSUE.
  - A flush in S_DRAIN stays in S_DRAIN and updates pc.
- Flush with stall: flush wins; the outputs are invalidated.
- Reset in any state (including mid-request) returns everything to reset values.
  - An imem response arriving after reset is ignored, because the FSM is in S_ISSUE and only S_WAIT/S_DRAIN consume rvalid.
  - The memory must be reset together with fetch.
- imem_rvalid outside S_WAIT/S_DRAIN is ignored (protocol violation, no state change).

Decomposition:
- Shared package/defines (alongside the existing def_params):
  - ADDR_SIZE and INSTR_SIZE width macros.
  - RESET_PC default.
  - FSM state encodings FETCH_S_ISSUE, FETCH_S_WAIT, FETCH_S_DRAIN.
- One sub-module: fetch_buf, a synchronous FIFO of {pc, instr} with width 64 and depth BUF_DEPTH.
  - Ports: push, pop, clear, full, empty, count.
  - clear has priority over push and pop.

Test Plan:
- Reset with RESET_PC = 0x100, gnt = 1, rvalid one cycle after each grant, rdata = addr^0xA5A5A5A5, no stall → PC_out sequence 0x100, 0x104, 0x108 with matching instr_out; valid stays high once streaming.
- Steady stream, then stall held for 5 cycles → outputs frozen on the same PC; FIFO fills to 2; imem_req stays 0 while full; after stall drops, the next two PCs emerge consecutively with no gap and no loss.
- Flush with redirect_pc = 0x203 while in S_WAIT; rvalid for old 0x10C arrives 2 cycles later → the 0x10C data is discarded; the next request address is 0x200; the first valid output is PC 0x200.
- Flush and stall both high in the same cycle while valid = 1 → pipeline_out_valid = 0 next cycle; FIFO count = 0.
- gnt held low for 4 cycles → imem_req and imem_addr remain stable; pc does not advance; no output valid.
- Reset asserted in S_WAIT, and a stale rvalid arrives the following cycle → outputs are 0/invalid; the stale data never appears; fetch restarts at RESET_PC.
